// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared LCD controller states, default timing and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int LCD_CLK_SETUP_DEF = 2;
    localparam int LCD_CLK_EN_DEF    = 16;
    localparam int LCD_CLK_HOLD_DEF  = 2;
    localparam int LCD_MAX_POLLS_DEF = 255;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_EN_HIGH = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_phase_timer
// Description : Loadable down-counter; expire is high on the last phase cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Stops at zero so the count can never wrap between phases.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_reader.sv
`default_nettype none
// ============================================================================
// Module      : lcd_reader
// Description : HD44780-style LCD read controller with optional busy polling.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int CLK_SETUP = LCD_CLK_SETUP_DEF,
    parameter int CLK_EN    = LCD_CLK_EN_DEF,
    parameter int CLK_HOLD  = LCD_CLK_HOLD_DEF,
    parameter int MAX_POLLS = LCD_MAX_POLLS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       iRS,
    input  logic       poll,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       BUS_REQ,
    output logic [7:0] RD_DATA,
    output logic       RD_DONE,
    output logic       TIMEOUT
);

    localparam int PH_MAX = lcd_max3(CLK_SETUP, CLK_EN, CLK_HOLD);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0] C_SETUP_LD = PH_W'(CLK_SETUP - 1);
    localparam logic [PH_W-1:0] C_EN_LD    = PH_W'(CLK_EN - 1);
    localparam logic [PH_W-1:0] C_HOLD_LD  = PH_W'(CLK_HOLD - 1);
    localparam logic [7:0]      C_MAX_POLL = 8'(MAX_POLLS);

    logic [2:0]      state_q,    state_d;
    logic            rs_q,       rs_d;
    logic            poll_en_q,  poll_en_d;
    logic [7:0]      poll_cnt_q, poll_cnt_d;
    logic [7:0]      rd_data_q,  rd_data_d;
    logic            timeout_q,  timeout_d;
    logic            en_q,       en_d;
    logic            act_q,      act_d;
    logic            done_q,     done_d;

    logic            ph_load;
    logic [PH_W-1:0] ph_val;
    logic            ph_expire;

    lcd_phase_timer #(
        .W (PH_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_val),
        .expire   (ph_expire)
    );

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        poll_en_d  = poll_en_q;
        poll_cnt_d = poll_cnt_q;
        rd_data_d  = rd_data_q;
        timeout_d  = timeout_q;
        ph_load    = 1'b0;
        ph_val     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rs_d       = iRS;
                    poll_en_d  = poll;
                    poll_cnt_d = 8'd0;
                    timeout_d  = 1'b0;
                    ph_load    = 1'b1;
                    ph_val     = C_SETUP_LD;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (ph_expire) begin
                    ph_load = 1'b1;
                    ph_val  = C_EN_LD;
                    state_d = ST_EN_HIGH;
                end
            end
            ST_EN_HIGH: begin
                if (ph_expire) begin
                    rd_data_d = LCD_DATA_IN;
                    ph_load   = 1'b1;
                    ph_val    = C_HOLD_LD;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ph_expire) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!poll_en_q || !rd_data_q[7]) begin
                    state_d = ST_DONE;
                end else if (poll_cnt_q < C_MAX_POLL) begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    ph_load    = 1'b1;
                    ph_val     = C_SETUP_LD;
                    state_d    = ST_SETUP;
                end else begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes come straight from flops so the LCD pins never see decode glitches.
    always_comb begin
        en_d   = (state_d == ST_EN_HIGH);
        act_d  = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rs_q       <= 1'b0;
            poll_en_q  <= 1'b0;
            poll_cnt_q <= 8'd0;
            rd_data_q  <= 8'h00;
            timeout_q  <= 1'b0;
            en_q       <= 1'b0;
            act_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            poll_en_q  <= poll_en_d;
            poll_cnt_q <= poll_cnt_d;
            rd_data_q  <= rd_data_d;
            timeout_q  <= timeout_d;
            en_q       <= en_d;
            act_q      <= act_d;
            done_q     <= done_d;
        end
    end

    assign LCD_EN  = en_q;
    assign LCD_RW  = act_q;
    assign BUS_REQ = act_q;
    assign LCD_RS  = rs_q;
    assign RD_DATA = rd_data_q;
    assign RD_DONE = done_q;
    assign TIMEOUT = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_reader
// Description : Randomized and directed bench for lcd_reader with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_reader;

    localparam int S    = 2;
    localparam int E    = 16;
    localparam int H    = 2;
    localparam int MAXP = 3;
    localparam int P    = S + E + H + 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic       iRS;
    logic       poll;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_EN;
    logic       LCD_RW;
    logic       LCD_RS;
    logic       BUS_REQ;
    logic [7:0] RD_DATA;
    logic       RD_DONE;
    logic       TIMEOUT;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] vals [0:MAXP];

    // Model: a transaction is a timeline of m_n reads of P cycles each, then DONE.
    bit         m_busy;
    int         m_t;
    int         m_n;
    logic [7:0] m_rd;
    logic       m_rs;
    logic       m_poll;
    logic       m_to;

    lcd_reader #(
        .CLK_SETUP (S),
        .CLK_EN    (E),
        .CLK_HOLD  (H),
        .MAX_POLLS (MAXP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .iRS         (iRS),
        .poll        (poll),
        .LCD_DATA_IN (LCD_DATA_IN),
        .LCD_EN      (LCD_EN),
        .LCD_RW      (LCD_RW),
        .LCD_RS      (LCD_RS),
        .BUS_REQ     (BUS_REQ),
        .RD_DATA     (RD_DATA),
        .RD_DONE     (RD_DONE),
        .TIMEOUT     (TIMEOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_n    = 1;
            m_rd   = 8'h00;
            m_rs   = 1'b0;
            m_poll = 1'b0;
            m_to   = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_rs   = iRS;
                m_poll = poll;
                m_n    = 1;
                while (m_poll && vals[m_n-1][7] && (m_n - 1) < MAXP) m_n++;
                m_to = m_poll && vals[m_n-1][7];
            end
        end else if (m_t == m_n * P + 1) begin
            m_busy = 1'b0;
        end else begin
            if (((m_t - 1) % P) == S + E - 1) m_rd = vals[(m_t - 1) / P];
            m_t++;
        end
    end

    // Bus model: the addressed byte is only valid while the enable pulse is up.
    always @(negedge clk) begin
        if (m_busy && m_t <= m_n * P && ((m_t - 1) % P) >= S && ((m_t - 1) % P) < S + E)
            LCD_DATA_IN = vals[(m_t - 1) / P];
        else
            LCD_DATA_IN = 8'($urandom);
    end

    always @(negedge clk) begin
        logic        exp_en;
        logic        exp_done;
        logic [13:0] exp_v;
        logic [13:0] act_v;
        exp_en   = 1'b0;
        exp_done = 1'b0;
        if (m_busy) begin
            if (m_t <= m_n * P)
                exp_en = ((m_t - 1) % P) >= S && ((m_t - 1) % P) < S + E;
            else
                exp_done = 1'b1;
        end
        exp_v = {exp_en, m_busy, m_rs, m_busy, exp_done, m_rd, exp_done ? m_to : 1'b0};
        act_v = {LCD_EN, LCD_RW, LCD_RS, BUS_REQ, RD_DONE, RD_DATA, RD_DONE ? TIMEOUT : 1'b0};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h (EN,RW,RS,BUS,DONE,DATA,TO)",
                     $time, act_v, exp_v);
        end
        if (LCD_EN) begin
            n_tests++;
            if (LCD_RW !== 1'b1) begin
                n_fail++;
                $display("FAIL en_implies_rw t=%0t actual RW=%b required 1", $time, LCD_RW);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_one(input string name, input logic rs, input logic pl,
                           input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input logic [7:0] v3,
                           input int exp_cyc, input int exp_pulses,
                           input logic [7:0] exp_rd, input logic exp_to);
        int   cyc;
        int   pulses;
        logic prev_en;
        bit   seen;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        iRS = rs; poll = pl; start = 1'b1;
        cyc = 0; pulses = 0; prev_en = 1'b0; seen = 1'b0;
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                iRS   = ~rs;
                poll  = ~pl;
            end
            if (LCD_EN && !prev_en) pulses++;
            prev_en = LCD_EN;
            if (RD_DONE) begin
                seen = 1'b1;
                chk({name, "_rd_data"}, RD_DATA, exp_rd);
                chk({name, "_timeout"}, TIMEOUT, exp_to);
                chk({name, "_rs"}, LCD_RS, rs);
            end
        end
        chk({name, "_done_cycle"}, cyc, exp_cyc);
        chk({name, "_en_pulses"}, pulses, exp_pulses);
        @(negedge clk);
        chk({name, "_rw_idle"}, LCD_RW, 0);
        chk({name, "_busreq_idle"}, BUS_REQ, 0);
    endtask

    initial begin
        int  cyc;
        int  highs;
        bit  seen;
        reset = 1'b1; start = 1'b0; iRS = 1'b0; poll = 1'b0;
        for (int i = 0; i <= MAXP; i++) vals[i] = 8'h00;

        @(negedge clk);
        chk("reset_state", {LCD_EN, LCD_RW, LCD_RS, BUS_REQ, RD_DONE, TIMEOUT, RD_DATA}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_one("single",  1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 22, 1, 8'hA5, 1'b0);
        run_one("poll_ok", 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h05, 85, 4, 8'h05, 1'b0);
        run_one("poll_to", 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 85, 4, 8'hFF, 1'b1);

        // Abort in the 5th enable cycle.
        vals[0] = 8'h5A; iRS = 1'b1; poll = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 4) @(negedge clk);
        chk("abort_en_before", LCD_EN, 1);
        #1 reset = 1'b1;
        #1;
        chk("abort_async_outputs", {LCD_EN, LCD_RW, BUS_REQ, RD_DONE}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        highs = 0;
        repeat (30) begin
            @(negedge clk);
            if (RD_DONE || BUS_REQ) highs++;
        end
        chk("abort_no_done", highs, 0);
        run_one("after_reset", 1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, 22, 1, 8'h3C, 1'b0);

        // start held high: one idle cycle between DONE and the next SETUP.
        vals[0] = 8'h42; iRS = 1'b0; poll = 1'b0; start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (RD_DONE) seen = 1'b1;
        end
        chk("b2b_first_done", cyc, 22);
        @(negedge clk);
        chk("b2b_idle_gap", BUS_REQ, 0);
        @(negedge clk);
        chk("b2b_restart", BUS_REQ, 1);
        start = 1'b0;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (RD_DONE) seen = 1'b1;
        end
        chk("b2b_second_done", cyc, 22);
        highs = 0;
        repeat (30) begin
            @(negedge clk);
            if (BUS_REQ) highs++;
        end
        chk("b2b_no_queue", highs, 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!m_busy && $urandom_range(0, 2) == 0) begin
                for (int i = 0; i <= MAXP; i++) begin
                    vals[i] = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) vals[i][7] = 1'b1;
                end
                start = 1'b1;
            end else begin
                start = ($urandom_range(0, 7) == 0);
            end
            iRS  = 1'($urandom);
            poll = 1'($urandom);
        end
        start = 1'b0;
        cyc = 0;
        while (m_busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_idle", m_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter CLK_SETUP, default 2: clocks RS/RW are held stable with LCD_EN low before the enable pulse.
REQ-002 Parameter CLK_EN, default 16: clocks LCD_EN is held high per read strobe.
REQ-003 Parameter CLK_HOLD, default 2: clocks RS/RW are held after LCD_EN falls.
REQ-004 Parameter MAX_POLLS, default 255: maximum busy-flag re-reads before timeout; range 1..255.
REQ-005 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  request one read transaction; sampled only in IDLE.
REQ-009 iRS  input  1  register select for the read: 0 = busy flag/address, 1 = data RAM.
REQ-010 poll  input  1  1 = repeat the read until bit 7 = 0; sampled with start.
REQ-011 LCD_DATA_IN  input  8  LCD data bus as seen by the FPGA.
REQ-012 LCD_EN  output  1  LCD enable strobe.
REQ-013 LCD_RW  output  1  1 = read; 0 whenever the block is in IDLE.
REQ-014 LCD_RS  output  1  latched register select.
REQ-015 BUS_REQ  output  1  high whenever the block is outside IDLE; the top level tri-states the writer's drive of LCD_DATA.
REQ-016 RD_DATA  output  8  last sampled byte; holds its value until the next sample.
REQ-017 RD_DONE  output  1  one-cycle pulse when a transaction ends, successfully or by timeout.
REQ-018 TIMEOUT  output  1  valid with RD_DONE: 1 = the poll limit was reached with bit 7 still set.

Function
REQ-019 The FSM states SHALL be IDLE, SETUP, EN_HIGH, HOLD, CHECK and DONE.
REQ-020 IDLE, with start=1: latch iRS and poll, clear the poll count, go to SETUP.
REQ-021 IDLE, with start=0: remain in IDLE.
REQ-022 SETUP: LCD_RW=1, LCD_RS=latched value, LCD_EN=0 for exactly CLK_SETUP cycles, then EN_HIGH.
REQ-023 EN_HIGH: LCD_EN=1 for exactly CLK_EN cycles; LCD_DATA_IN is registered into RD_DATA on the last EN_HIGH cycle, then HOLD.
REQ-024 HOLD: LCD_EN=0 with RW/RS unchanged for exactly CLK_HOLD cycles, then CHECK.
REQ-025 CHECK lasts one cycle.
REQ-026 CHECK, if poll=0 or RD_DATA[7]=0: go to DONE with TIMEOUT=0.
REQ-027 CHECK, if poll=1, RD_DATA[7]=1 and poll count < MAX_POLLS: increment the count and go to SETUP.
REQ-028 CHECK, if poll=1, RD_DATA[7]=1 and poll count = MAX_POLLS: go to DONE with TIMEOUT=1.
REQ-029 DONE: RD_DONE=1 for one cycle, then IDLE.
REQ-030 Single-read latency: RD_DONE is high exactly CLK_SETUP+CLK_EN+CLK_HOLD+2 cycles after the edge that accepted start (22 cycles with default parameters).
REQ-031 Each poll repetition adds CLK_SETUP+CLK_EN+CLK_HOLD+1 cycles (21 with default parameters).
REQ-032 start outside IDLE, including in the DONE cycle, SHALL be ignored and never queued.
REQ-033 Changes on iRS or poll outside IDLE SHALL have no effect.
REQ-034 The phase counter SHALL be wide enough for max(CLK_SETUP, CLK_EN, CLK_HOLD) and SHALL never wrap.
REQ-035 The poll counter SHALL be 8 bits and saturate at MAX_POLLS.
REQ-036 LCD_EN SHALL never be high in the same cycle that LCD_RW or LCD_RS changes.

Reset
REQ-037 On reset assertion, immediately: state=IDLE, LCD_EN=0, LCD_RW=0, LCD_RS=0, BUS_REQ=0, RD_DONE=0, TIMEOUT=0, RD_DATA=8'h00, counters=0.
REQ-038 Reset mid-transaction SHALL abort the transaction with no RD_DONE pulse; the first start after reset release begins a fresh transaction.

Structure
REQ-039 The state enum and the default timing constants SHALL live in the shared package lcd_pkg, reused by the LCD write controller.
REQ-040 Phase timing SHALL be implemented in one sub-module, lcd_phase_timer: load a count, decrement, raise expire on the last cycle.

Verification
REQ-041 poll=0, iRS=1, LCD_DATA_IN=8'hA5 -> LCD_EN high exactly 16 cycles; RD_DATA=8'hA5; RD_DONE at cycle 22 with TIMEOUT=0; LCD_RW back to 0 in IDLE.
REQ-042 poll=1, iRS=0, bus model returns 8'h80 for 3 reads then 8'h05 -> 4 EN pulses; RD_DONE at cycle 22+3*21=85; RD_DATA=8'h05; TIMEOUT=0.
REQ-043 poll=1, MAX_POLLS=3, bus held at 8'hFF -> 4 EN pulses, then RD_DONE with TIMEOUT=1 and RD_DATA=8'hFF.
REQ-044 Reset asserted in the 5th EN_HIGH cycle -> LCD_EN, LCD_RW and BUS_REQ fall without waiting for a clock edge; no RD_DONE; a new start after release completes normally in 22 cycles.
REQ-045 start held high continuously -> back-to-back transactions with exactly one IDLE cycle between RD_DONE and the next SETUP; no extra transactions are queued.
REQ-046 Assertion checks on every test: LCD_EN=1 implies LCD_RW=1; RS/RW stable from CLK_SETUP cycles before LCD_EN rises until CLK_HOLD cycles after it falls.
